// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } loader_state_t;

  localparam logic [7:0] CSUM_INIT = 8'h00;

  // Frame byte order: two length bytes, payload words, then the checksum byte.
  localparam int BYTE_LEN_LO    = 0;
  localparam int BYTE_LEN_HI    = 1;
  localparam int BYTE_PAYLOAD   = 2;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [1:0] LANE_LAST = 2'(BYTES_PER_WORD - 1);

  function automatic logic [16:0] MAX_WORDS(input int addr_width);
    return 17'(1) << addr_width;
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; word_valid flags the
// accept of the fourth byte, with that byte presented combinationally on top.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  lane;
  logic [23:0] low_bytes;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      lane      <= 2'd0;
      low_bytes <= 24'd0;
    end else if (byte_valid) begin
      lane <= lane + 2'd1;
      case (lane)
        2'd0:    low_bytes[7:0]   <= byte_data;
        2'd1:    low_bytes[15:8]  <= byte_data;
        2'd2:    low_bytes[23:16] <= byte_data;
        default: low_bytes        <= low_bytes;
      endcase
    end
  end

  assign word       = {byte_data, low_bytes};
  assign word_valid = byte_valid && (lane == LANE_LAST);

endmodule

// File: rtl/imem_loader.sv
// Receives a length-prefixed, XOR-checksummed byte frame and writes it into
// instruction memory, holding the core in reset until the load verifies.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_write,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_data,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] words_loaded
);

  localparam logic [16:0] CAPACITY = MAX_WORDS(ADDR_WIDTH);

  loader_state_t state, next_state;

  logic        accept;
  logic        byte_valid;
  logic        word_valid;
  logic [31:0] word;
  logic [7:0]  len_lo;
  logic [15:0] len_rx;
  logic [15:0] word_count;
  logic [15:0] word_idx;
  logic [7:0]  csum;

  assign rx_ready   = ~imem_write;
  assign accept     = rx_valid & rx_ready;
  assign len_rx     = {rx_data, len_lo};
  assign byte_valid = accept && (state == S_DATA);

  word_assembler u_assembler (
    .clock      (clock),
    .reset      (reset),
    .clear      (state != S_DATA),
    .byte_valid (byte_valid),
    .byte_data  (rx_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= S_LEN_LO;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_LEN_LO: if (accept) next_state = S_LEN_HI;
      S_LEN_HI: begin
        if (accept) begin
          if ({1'b0, len_rx} > CAPACITY) next_state = S_ERROR;
          else if (len_rx == 16'd0)      next_state = S_CSUM;
          else                           next_state = S_DATA;
        end
      end
      S_DATA: begin
        if (word_valid && (word_idx == word_count - 16'd1)) next_state = S_CSUM;
      end
      S_CSUM: begin
        if (accept) next_state = (rx_data == csum) ? S_DONE : S_ERROR;
      end
      S_DONE:  next_state = S_DONE;
      S_ERROR: next_state = S_ERROR;
      default: next_state = S_ERROR;
    endcase
  end

  // Status flags follow next_state so they rise on the same edge the FSM
  // commits to a terminal state.
  always_ff @(posedge clock) begin
    if (reset) begin
      imem_write   <= 1'b0;
      imem_addr    <= 32'd0;
      imem_data    <= 32'd0;
      cpu_hold     <= 1'b1;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= 16'd0;
      len_lo       <= 8'd0;
      word_count   <= 16'd0;
      word_idx     <= 16'd0;
      csum         <= CSUM_INIT;
    end else begin
      imem_write <= word_valid;
      cpu_hold   <= (next_state != S_DONE);
      load_done  <= load_done  | (next_state == S_DONE);
      load_error <= load_error | (next_state == S_ERROR);

      if (state == S_LEN_LO) begin
        csum <= CSUM_INIT;
        if (accept) len_lo <= rx_data;
      end

      if (state == S_LEN_HI && accept) word_count <= len_rx;

      if (byte_valid) csum <= csum ^ rx_data;

      if (word_valid) begin
        imem_addr    <= {{(32 - ADDR_WIDTH){1'b0}}, word_idx[ADDR_WIDTH-1:0]};
        imem_data    <= word;
        word_idx     <= word_idx + 16'd1;
        words_loaded <= word_idx + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scoreboard of expected memory writes
// plus status checks at the exact cycle each frame ends.
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        imem_write;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;
  logic [15:0] words_loaded;

  int n_checks = 0;
  int n_fail = 0;
  int write_count = 0;
  int max_gap = 0;
  int writes_before;

  logic [63:0] exp_q[$];
  logic [31:0] frame_words[$];

  imem_loader #(.ADDR_WIDTH(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_write   (imem_write),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Write monitor: every write pulse must match the oldest expected write.
  always @(negedge clock) begin
    if (!reset) begin
      checkOutput("rx_ready_vs_write", rx_ready, !imem_write);
      if (imem_write) begin
        logic [63:0] exp_w;
        write_count++;
        if (exp_q.size() == 0) begin
          checkOutput("write_with_empty_queue", imem_write, 1'b0);
        end else begin
          exp_w = exp_q.pop_front();
          checkOutput("write_addr", imem_addr, exp_w[63:32]);
          checkOutput("write_data", imem_data, exp_w[31:0]);
          checkOutput("words_loaded_at_write", words_loaded, exp_w[63:32] + 64'd1);
        end
      end
    end
  end

  // Starts and ends on a falling edge; returns in the cycle after acceptance.
  task automatic send_byte(input logic [7:0] b);
    int gap;
    int waited;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) begin
      rx_valid = 1'b0;
      @(negedge clock);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    waited   = 0;
    while (!rx_ready && waited < 8) begin
      @(negedge clock);
      waited++;
    end
    if (!rx_ready) begin
      checkOutput("rx_ready_timeout", rx_ready, 1'b1);
    end else begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  // Sends a frame from frame_words; stop_after >= 0 truncates the payload.
  task automatic applyStimulus(input int n, input bit bad_csum, input int stop_after);
    logic [7:0]  x;
    logic [31:0] w;
    int sent;
    x = 8'h00;
    sent = 0;
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    for (int i = 0; i < n; i++) begin
      w = frame_words[i];
      if (stop_after < 0 || (i + 1) * 4 <= stop_after) exp_q.push_back({32'(i), w});
      for (int b = 0; b < 4; b++) begin
        if (stop_after >= 0 && sent >= stop_after) begin
          rx_valid = 1'b0;
          return;
        end
        send_byte(w[8*b +: 8]);
        x = x ^ w[8*b +: 8];
        sent++;
      end
    end
    send_byte(bad_csum ? ~x : x);
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset    = 1'b1;
    rx_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_reset_state(input string tag);
    checkOutput({tag, "_imem_write"}, imem_write, 1'b0);
    checkOutput({tag, "_imem_addr"}, imem_addr, 32'd0);
    checkOutput({tag, "_imem_data"}, imem_data, 32'd0);
    checkOutput({tag, "_cpu_hold"}, cpu_hold, 1'b1);
    checkOutput({tag, "_load_done"}, load_done, 1'b0);
    checkOutput({tag, "_load_error"}, load_error, 1'b0);
    checkOutput({tag, "_words_loaded"}, words_loaded, 16'd0);
    checkOutput({tag, "_rx_ready"}, rx_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_reset_state("por");

    // Two-word load, rx_valid held high through the write cycles.
    $display("[TB] two-word load");
    max_gap = 0;
    frame_words.delete();
    frame_words.push_back(32'hE3A00001);
    frame_words.push_back(32'hE2800002);
    writes_before = write_count;
    applyStimulus(2, 1'b0, -1);
    checkOutput("t1_load_done", load_done, 1'b1);
    checkOutput("t1_cpu_hold", cpu_hold, 1'b0);
    checkOutput("t1_load_error", load_error, 1'b0);
    checkOutput("t1_words_loaded", words_loaded, 16'd2);
    checkOutput("t1_write_count", write_count - writes_before, 2);
    checkOutput("t1_pending", exp_q.size(), 0);

    // One word, corrupted checksum.
    $display("[TB] bad checksum");
    do_reset();
    check_reset_state("t2_rst");
    frame_words.delete();
    frame_words.push_back(32'hDEADBEEF);
    writes_before = write_count;
    applyStimulus(1, 1'b1, -1);
    checkOutput("t2_load_error", load_error, 1'b1);
    checkOutput("t2_cpu_hold", cpu_hold, 1'b1);
    checkOutput("t2_load_done", load_done, 1'b0);
    checkOutput("t2_write_count", write_count - writes_before, 1);
    checkOutput("t2_pending", exp_q.size(), 0);

    // Empty frame.
    $display("[TB] zero-length frame");
    do_reset();
    frame_words.delete();
    writes_before = write_count;
    applyStimulus(0, 1'b0, -1);
    checkOutput("t3_load_done", load_done, 1'b1);
    checkOutput("t3_cpu_hold", cpu_hold, 1'b0);
    checkOutput("t3_write_count", write_count - writes_before, 0);

    // Length one past capacity; trailing bytes must still be accepted.
    $display("[TB] length overflow");
    do_reset();
    writes_before = write_count;
    send_byte(8'h01);
    send_byte(8'h01);
    rx_valid = 1'b0;
    checkOutput("t4_load_error", load_error, 1'b1);
    checkOutput("t4_cpu_hold", cpu_hold, 1'b1);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom));
    rx_valid = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("t4_write_count", write_count - writes_before, 0);
    checkOutput("t4_words_loaded", words_loaded, 16'd0);
    checkOutput("t4_load_done", load_done, 1'b0);
    checkOutput("t4_load_error_sticky", load_error, 1'b1);

    // Random gaps between bytes.
    $display("[TB] random gaps");
    do_reset();
    max_gap = 3;
    frame_words.delete();
    for (int i = 0; i < 6; i++) frame_words.push_back($urandom);
    writes_before = write_count;
    applyStimulus(6, 1'b0, -1);
    checkOutput("t5_load_done", load_done, 1'b1);
    checkOutput("t5_cpu_hold", cpu_hold, 1'b0);
    checkOutput("t5_words_loaded", words_loaded, 16'd6);
    checkOutput("t5_write_count", write_count - writes_before, 6);
    checkOutput("t5_pending", exp_q.size(), 0);

    // Abort after six payload bytes, then a fresh single-word frame.
    $display("[TB] reset mid-load");
    do_reset();
    max_gap = 0;
    frame_words.delete();
    frame_words.push_back(32'hA5A55A5A);
    frame_words.push_back(32'h0F0F0F0F);
    applyStimulus(2, 1'b0, 6);
    @(negedge clock);
    checkOutput("t6_pending_before_reset", exp_q.size(), 0);
    do_reset();
    check_reset_state("t6_rst");
    frame_words.delete();
    frame_words.push_back(32'h12345678);
    writes_before = write_count;
    applyStimulus(1, 1'b0, -1);
    checkOutput("t6_load_done", load_done, 1'b1);
    checkOutput("t6_cpu_hold", cpu_hold, 1'b0);
    checkOutput("t6_words_loaded", words_loaded, 16'd1);
    checkOutput("t6_write_count", write_count - writes_before, 1);
    checkOutput("t6_pending", exp_q.size(), 0);

    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the processor's instruction memory. It accepts a framed byte stream from a host link, assembles little-endian 32-bit instruction words, and writes them to consecutive word addresses of instruction memory. The processor is held in reset the whole time, and is released only after a checksum-verified load. The block sits between the host byte link and the instruction memory write port, and drives the core's reset-hold.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: instruction-memory word-address width; capacity is 2^ADDR_WIDTH words.

Ports:
- `clock`  in  1  — single clock for the block.
- `reset`  in  1  — synchronous, active-high.
- `rx_data`  in  8  — host byte.
- `rx_valid`  in  1  — `rx_data` is valid.
- `rx_ready`  out  1  — loader can take a byte; a byte transfers on a rising edge with `rx_valid & rx_ready`.
- `imem_write`  out  1  — one-cycle write strobe to instruction memory.
- `imem_addr`  out  32  — word address, zero-extended from ADDR_WIDTH bits.
- `imem_data`  out  32  — instruction word to write.
- `cpu_hold`  out  1  — holds the processor in reset; high until a successful load.
- `load_done`  out  1  — sticky; load completed and checksum matched.
- `load_error`  out  1  — sticky; length overflow or checksum mismatch.
- `words_loaded`  out  16  — count of words written.

## Operation
- Frame format: `LEN_LO`, `LEN_HI` (word count N, little-endian), then 4·N payload bytes (each word little-endian, byte 0 = bits 7:0), then one `CSUM` byte.
- `CSUM` is the XOR of all 4·N payload bytes; the length bytes are excluded.
- States are `S_LEN_LO`, `S_LEN_HI`, `S_DATA`, `S_CSUM`, `S_DONE` and `S_ERROR`.
  - `S_LEN_LO` → `S_LEN_HI` on an accepted byte.
  - `S_LEN_HI` → `S_ERROR` if N > 2^ADDR_WIDTH.
  - `S_LEN_HI` → `S_CSUM` if N = 0.
  - `S_LEN_HI` → `S_DATA` otherwise.
  - `S_DATA`: a lane counter (0..3) shifts bytes in. On lane 3 accept, the assembled word is registered and written. After word N−1 the FSM moves to `S_CSUM`.
  - `S_CSUM` → `S_DONE` if the received byte equals the running XOR; otherwise → `S_ERROR`.
- Accumulator rules:
  - The running XOR is cleared on entry to `S_LEN_LO` and updated only with payload bytes.
  - The word index is 16-bit, starts at 0 and increments after each write. It never wraps, because of the overflow check.
- `S_DONE` and `S_ERROR` are terminal. `rx_ready` stays 1 in both, and accepted bytes are discarded (the host never stalls). The only exit is `reset`.
- `cpu_hold` stays 1 in every state except `S_DONE`.

## Timing
- Reset values:
  - `imem_write` = 0, `imem_addr` = 0, `imem_data` = 0
  - `cpu_hold` = 1, `load_done` = 0, `load_error` = 0, `words_loaded` = 0
  - `rx_ready` = 1
  - state = `S_LEN_LO`, XOR = 0
- Reset asserted mid-load aborts the load: all of the above values apply on the next edge, and any partial word is dropped.
- All outputs are registered except `rx_ready`, which is defined as `~imem_write`.
- Write latency: the edge that accepts byte 3 of word k sets up the write for the next cycle.
  - In that cycle, `imem_write` = 1, `imem_addr` = k, and `imem_data` = the assembled word.
  - `words_loaded` = k+1 from that same edge.
  - `rx_ready` is 0 for that one cycle. The memory samples the write on the following edge.
- Maximum throughput is therefore 4 bytes per 5 cycles in `S_DATA`, and 1 byte per cycle elsewhere.
- Checksum byte accepted with a match: on the next edge, `load_done` = 1 and `cpu_hold` = 0 in the same cycle.
- Checksum byte accepted with a mismatch: on the next edge, `load_error` = 1 and `cpu_hold` stays 1.
- Overflow: `load_error` = 1 on the edge after `LEN_HI` is accepted, and no write ever occurs.
- `rx_valid` low holds all state; gaps between bytes are unlimited.
- `imem_addr` and `imem_data` hold their last values after the write; only the `imem_write` pulse is meaningful.

## Structure
- Package `imem_loader_pkg` contains:
  - the state enum `loader_state_t`
  - `CSUM_INIT` = 8'h00
  - the frame byte-order constants
  - the `MAX_WORDS(ADDR_WIDTH)` helper function
- Sub-module `word_assembler`: an 8→32 shift register with a 2-bit lane counter, a clear input, and a `word_valid` pulse on the lane-3 accept. The top level keeps the FSM, XOR accumulator, address counter and status flags.

## Test plan
- N=2, words 32'hE3A00001 and 32'hE2800002, correct CSUM:
  - `imem_write` pulses twice, with addr 0 then addr 1 and the exact words.
  - `load_done` = 1, `cpu_hold` = 0, `words_loaded` = 2.
- N=1 with a wrong CSUM: one write occurs, then `load_error` = 1, `cpu_hold` stays 1, and `load_done` stays 0.
- N=0 with CSUM 8'h00: no writes, `load_done` = 1 on the edge after CSUM.
- ADDR_WIDTH=8, N=257: `load_error` = 1 one cycle after `LEN_HI`, with zero writes; the following bytes are still accepted and ignored.
- Random `rx_valid` gaps, plus `rx_valid` held high through a write cycle: `rx_ready` = 0 only during `imem_write`, with no byte lost or duplicated.
- `reset` pulsed after 6 payload bytes, then a fresh valid N=1 frame: the first write goes to addr 0 with the new word, and `load_done` = 1.
